// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ simple requesters onto one APB4 master port.
// Optional ACCESS-phase PREADY timeout is built when APB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*4-1:0]   req_strb,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            PADDR,
  output logic [31:0]            PWDATA,
  output logic                   PWRITE,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic [3:0]             PSTRB,
  input  logic [31:0]            PRDATA,
  input  logic                   PSLVERROR,
  input  logic                   PREADY
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_grant_q;
  logic [GW-1:0]   grant_idx;
  logic            grant_found;
  logic            xfer_done;
  logic            arb_en;
  logic            tmo_hit;
  int unsigned     rr_idx;

  logic [31:0] addr_a  [NUM_REQ];
  logic [31:0] wdata_a [NUM_REQ];
  logic [3:0]  strb_a  [NUM_REQ];

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("apb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC nonzero");
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*32 +: 32];
    assign wdata_a[g] = req_wdata[g*32 +: 32];
    assign strb_a[g]  = req_strb[g*4 +: 4];
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q;

  // Counts PREADY-low ACCESS cycles; the transfer is abandoned on the TIMEOUT_CYC-th one.
  always_ff @(posedge HCLK) begin
    if (HRESET || state_d == SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !PREADY) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  assign tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign xfer_done = (state_q == ACCESS) && (PREADY || tmo_hit);
  assign arb_en    = (state_q == IDLE) || xfer_done;

  // Next state, round-robin pick (search from last_grant+1) and the accept pulse.
  always_comb begin
    state_d     = state_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    req_ready   = '0;

    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (32'(last_grant_q) + 32'(k)) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && rr_idx == 32'(i) && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = GW'(i);
        end
      end
    end

    case (state_q)
      IDLE:    if (grant_found) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = grant_found ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    if (arb_en && grant_found && !HRESET) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // State register, latched command and registered APB / response outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      PSTRB        <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      PSEL    <= (state_d != IDLE);
      PENABLE <= (state_d == ACCESS);

      if (arb_en && grant_found) begin
        last_grant_q <= grant_idx;
        PADDR        <= addr_a[grant_idx];
        PWDATA       <= wdata_a[grant_idx];
        PWRITE       <= req_write[grant_idx];
        PSTRB        <= req_write[grant_idx] ? strb_a[grant_idx] : 4'b0000;
      end

      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (xfer_done) begin
        rsp_valid[last_grant_q] <= 1'b1;
        rsp_err                 <= tmo_hit ? 1'b1 : PSLVERROR;
        rsp_rdata               <= (PWRITE || tmo_hit) ? 32'h0 : PRDATA;
      end
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, ACCESS-phase PREADY timeout in cycles (used only with APB_TIMEOUT_EN).
REQ-003 SHALL have port HCLK  input  1  single clock; every flop updates on its rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester transfer request, held until accepted.
REQ-006 SHALL have ports req_addr, req_wdata  input  NUM_REQ*32  packed per-requester address and write data; slice i belongs to requester i.
REQ-007 SHALL have ports req_write  input  NUM_REQ  and req_strb  input  NUM_REQ*4  per-requester direction and byte strobes.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-009 SHALL have ports rsp_valid  output  NUM_REQ  (one-cycle completion pulse), rsp_rdata  output  32  and rsp_err  output  1  (shared, valid with rsp_valid).
REQ-010 SHALL have APB4 master ports PADDR/PWDATA out 32, PWRITE/PSEL/PENABLE out 1, PSTRB out 4, PRDATA in 32, PSLVERROR in 1, PREADY in 1.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-012 IDLE: when any req_valid is high, SHALL grant one requester, pulse its req_ready, latch its addr/wdata/write/strb and enter SETUP next cycle; otherwise SHALL stay in IDLE.
REQ-013 Grant SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ; last_grant SHALL update only on a grant.
REQ-014 SETUP: PSEL=1, PENABLE=0, APB outputs from latched command; unconditional move to ACCESS.
REQ-015 ACCESS: PSEL=1, PENABLE=1; SHALL hold all APB outputs stable while PREADY=0.
REQ-016 ACCESS with PREADY=1: SHALL pulse rsp_valid[granted] in the next cycle, with rsp_rdata=PRDATA for reads, 0 for writes, and rsp_err=PSLVERROR.
REQ-017 ACCESS with PREADY=1 and any req_valid high: SHALL re-arbitrate in the same cycle and go directly to SETUP (back-to-back, 2 cycles/transfer minimum); otherwise SHALL go to IDLE with PSEL=0.
REQ-018 A requester whose transfer completes in the same cycle SHALL be lowest priority in that arbitration.
REQ-019 PSTRB SHALL be 4'b0000 for reads regardless of req_strb; for writes SHALL equal latched req_strb.
REQ-020 In IDLE, PSEL=0, PENABLE=0; PADDR/PWDATA/PWRITE/PSTRB SHALL hold the last values.
REQ-021 req_ready SHALL never be high for more than one requester, and SHALL never be high in SETUP or mid-ACCESS.
REQ-022 Requester deasserting req_valid before req_ready SHALL cause no transfer.

Reset
REQ-023 On HRESET=1 at a clock edge: state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA=0; PSTRB=0; req_ready, rsp_valid, rsp_err=0; rsp_rdata=0; last_grant=NUM_REQ-1 (requester 0 first).
REQ-024 Reset during SETUP/ACCESS SHALL drop PSEL/PENABLE at that edge and SHALL NOT issue rsp_valid for the aborted transfer.

Configuration
REQ-025 Macro APB_TIMEOUT_EN defined: SHALL count ACCESS cycles with PREADY=0; once the count reaches TIMEOUT_CYC, SHALL end the transfer (PSEL=0 next cycle), pulse rsp_valid with rsp_err=1, rsp_rdata=0, then proceed per REQ-017. The counter SHALL clear on every SETUP entry.
REQ-026 Macro APB_TIMEOUT_EN undefined: SHALL have no timeout counter, and ACCESS SHALL wait indefinitely for PREADY.

Verification
REQ-027 Single write: req0 addr 0x1000, wdata 0xCAFEF00D, strb 0xF, PREADY=1 -> PSEL rises 1 cycle after req_ready[0], PENABLE next cycle; rsp_valid[0], rsp_err=0.
REQ-028 Read with 3 wait states: req1 read 0x2004, PRDATA=0x12345678 on the 4th ACCESS cycle -> APB outputs stable 4 cycles; rsp_rdata=0x12345678; PSTRB=0.
REQ-029 Contention: req0 and req1 both valid continuously, PREADY=1 -> grants 0,1,0,1; PSEL high continuously; 2 cycles/transfer.
REQ-030 Slave error: PSLVERROR=1 with PREADY=1 on write to 0x3000 -> rsp_err=1 for exactly one cycle with rsp_valid.
REQ-031 Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=16): PREADY held 0 -> after 16 ACCESS cycles rsp_valid with rsp_err=1, rsp_rdata=0, PSEL=0; without macro, still in ACCESS after 100 cycles.
REQ-032 Reset mid-ACCESS: HRESET=1 for 1 cycle during a wait state -> all outputs 0 at that edge, no rsp_valid; next request granted to requester 0.
